result_drain_buffer: RTL
========================

# result_drain_buffer

Output-side counterpart of the input switch buffer in the conv accelerator. Collects result words from the PE array into an internal FIFO. Once a full burst has accumulated, it issues a write-master request with a burst address. It then streams that burst to the write master over a valid/ready interface and waits for write completion. It repeats this until TOTAL_WORDS words of the current convolution have been written, then reports completion until `end_conv`.

## Interface
Parameters:
- DATA_WIDTH, 512, bits per word
- DATA_NUM, 64, bytes per word (address stride per word)
- BURST_LENGTH, 4, words per write burst
- FIFO_ADDR_WIDTH, 10, FIFO depth = 2^FIFO_ADDR_WIDTH words
- TOTAL_WORDS, 988, words produced per convolution; must be a nonzero multiple of BURST_LENGTH and ≤ 2^32−1

Ports (reset: rst_n, asynchronous, active-low; clock: clk):
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- push_req  in  1  PE result word valid; accepted when push_rdy=1
- push_data  in  DATA_WIDTH  PE result word
- push_rdy  out  1  !fifo_full
- addr_base  in  64  output tensor base address, held stable during operation
- addr_offset  out  64  write address of current burst
- wmst_req  out  1  one-cycle burst request to write master
- wmst_done  in  1  one-cycle pulse: current burst committed to memory
- tdata  out  DATA_WIDTH  FIFO head word
- tvalid  out  1  tdata valid toward write master
- tready  in  1  write master accepts beat
- op_start  in  1  start pulse for a convolution
- end_conv  in  1  synchronous clear of FIFO, counters, FSM
- drain_done  out  1  all TOTAL_WORDS written
- err_ovf  out  1  sticky: push attempted while full

## Operation
- FIFO:
  - Circular, show-ahead: tdata = mem[rd_ptr] combinationally.
  - cnt width FIFO_ADDR_WIDTH+1; pointers wrap modulo depth.
- Push and pop:
  - Push = push_req & push_rdy. Pop = tvalid & tready.
  - Simultaneous push and pop: cnt unchanged, both pointers advance.
  - Push while full is dropped, even if a pop occurs the same cycle, and sets err_ovf.
  - Pushes are accepted in every FSM state.
- Counters: burst_cnt (32b) counts completed bursts; beat_cnt counts 0..BURST_LENGTH−1.
- Address: addr_offset = addr_base + burst_cnt*DATA_NUM*BURST_LENGTH, combinational, 64-bit, wraps modulo 2^64.
- FSM states: IDLE, WAIT_DATA, REQ, STREAM, WAIT_DONE, DONE.
  - IDLE: on op_start, go to WAIT_DATA with burst_cnt=0 and beat_cnt=0. op_start in any other state is ignored.
  - WAIT_DATA: go to REQ when cnt ≥ BURST_LENGTH.
  - REQ: wmst_req=1 for exactly this cycle, then go to STREAM.
  - STREAM: tvalid=1. Each pop increments beat_cnt. On the pop with beat_cnt=BURST_LENGTH−1, clear beat_cnt and go to WAIT_DONE. tvalid never drops mid-burst; data is guaranteed by the REQ entry condition.
  - WAIT_DONE: on wmst_done, increment burst_cnt. If the new value equals TOTAL_WORDS/BURST_LENGTH, go to DONE; otherwise go to WAIT_DATA.
  - DONE: drain_done=1. Leave only via end_conv.
- Ignored inputs: wmst_done outside WAIT_DONE.
- end_conv, in any state:
  - Next cycle: FSM=IDLE; FIFO empty (pointers and cnt zeroed); burst_cnt=0, beat_cnt=0; drain_done=0; err_ovf=0.
  - end_conv has priority over op_start, push, pop and wmst_done in the same cycle.
- Reset mid-operation: identical clearing, asynchronous.

## Timing
- Reset values:
  - wmst_req=0, tvalid=0, drain_done=0, err_ovf=0, push_rdy=1.
  - addr_offset=addr_base; tdata undefined.
- FSM transitions are registered; each state change takes one clk.
  - op_start at cycle t: WAIT_DATA at t+1.
  - If cnt ≥ BURST_LENGTH at t+1: REQ (wmst_req=1) at t+2, first tvalid at t+3.
- Burst streaming: with tready held high, BURST_LENGTH beats are transferred in BURST_LENGTH consecutive cycles.
- Pushed data: a word pushed at cycle t is counted from t+1, and is visible on tdata at t+1 if the FIFO was empty.
- addr_offset is stable from REQ through WAIT_DONE, and updates the cycle after wmst_done.
- FIFO status: push_rdy and err_ovf are updated registered-cnt based, one cycle after the causing event.
- drain_done asserts the cycle after the final wmst_done.

## Test plan
- Config for all scenarios: TOTAL_WORDS=8, BURST_LENGTH=4, addr_base=0x1000.
- Normal drain:
  - Stimulus: push 8 words, op_start, tready=1, wmst_done 3 cycles after each burst's last beat.
  - Required response:
    - Two wmst_req pulses with addr_offset 0x1000 then 0x1100.
    - tdata order equals push order.
    - drain_done=1 after the 2nd wmst_done.
- Backpressure:
  - Stimulus: toggle tready 1/0 every cycle during STREAM.
  - Required response: tvalid held high, no duplicated or skipped words, exactly 4 beats per burst.
- Partial data:
  - Stimulus: op_start with 3 words buffered.
  - Required response: no wmst_req until the 4th push; wmst_req 2 cycles after that push.
- Overflow (FIFO_ADDR_WIDTH=2):
  - Stimulus: push 5 words with no op_start.
  - Required response: push_rdy=0 after 4 pushes, 5th word dropped, err_ovf=1.
- end_conv mid-burst:
  - Stimulus: assert end_conv after 2 beats of burst 0.
  - Required response: tvalid=0 and FIFO empty next cycle; a following op_start plus 8 pushes restarts at addr_offset 0x1000.

Source files
------------

// File: rtl/result_drain_buffer.sv
// result_drain_buffer: buffers PE result words and drains them to the write
// master in fixed-length bursts until a full convolution's output is written.
module result_drain_buffer #(
  parameter int unsigned DATA_WIDTH      = 512,
  parameter int unsigned DATA_NUM        = 64,
  parameter int unsigned BURST_LENGTH    = 4,
  parameter int unsigned FIFO_ADDR_WIDTH = 10,
  parameter int unsigned TOTAL_WORDS     = 988
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_req,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic                  push_rdy,
  input  logic [63:0]           addr_base,
  output logic [63:0]           addr_offset,
  output logic                  wmst_req,
  input  logic                  wmst_done,
  output logic [DATA_WIDTH-1:0] tdata,
  output logic                  tvalid,
  input  logic                  tready,
  input  logic                  op_start,
  input  logic                  end_conv,
  output logic                  drain_done,
  output logic                  err_ovf
);

  localparam int unsigned DEPTH       = 1 << FIFO_ADDR_WIDTH;
  localparam int unsigned CNT_W       = FIFO_ADDR_WIDTH + 1;
  localparam int unsigned BEAT_W      = (BURST_LENGTH > 1) ? $clog2(BURST_LENGTH) : 1;
  localparam int unsigned NUM_BURSTS  = TOTAL_WORDS / BURST_LENGTH;
  localparam logic [63:0] BURST_BYTES = 64'(DATA_NUM) * 64'(BURST_LENGTH);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_DATA, S_REQ, S_STREAM, S_WAIT_DONE, S_DONE
  } state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [DATA_WIDTH-1:0]      r_mem [DEPTH];
  logic [FIFO_ADDR_WIDTH-1:0] r_wr_ptr;
  logic [FIFO_ADDR_WIDTH-1:0] r_rd_ptr;
  logic [CNT_W-1:0]           r_cnt;
  logic [31:0]                r_burst_cnt;
  logic [BEAT_W-1:0]          r_beat_cnt;
  logic                       r_wmst_req;
  logic                       r_tvalid;
  logic                       r_drain_done;
  logic                       r_err_ovf;
  logic                       w_push;
  logic                       w_pop;
  logic                       w_last_beat;
  logic                       w_last_burst;

  assign push_rdy     = (r_cnt != CNT_W'(DEPTH));
  assign w_push       = push_req & push_rdy & ~end_conv;
  assign w_pop        = r_tvalid & tready & ~end_conv;
  assign w_last_beat  = (r_beat_cnt == BEAT_W'(BURST_LENGTH - 1));
  assign w_last_burst = ((r_burst_cnt + 32'd1) == 32'(NUM_BURSTS));

  assign tdata       = r_mem[r_rd_ptr];
  assign addr_offset = addr_base + (64'(r_burst_cnt) * BURST_BYTES);
  assign wmst_req    = r_wmst_req;
  assign tvalid      = r_tvalid;
  assign drain_done  = r_drain_done;
  assign err_ovf     = r_err_ovf;

  // FIFO storage: data array carries no reset, validity lives in r_cnt
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else if (end_conv) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + FIFO_ADDR_WIDTH'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + FIFO_ADDR_WIDTH'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Sticky overflow flag: a push attempt while full is dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_err_ovf <= 1'b0;
    else if (end_conv) r_err_ovf <= 1'b0;
    else if (push_req && !push_rdy) r_err_ovf <= 1'b1;
  end

  // Burst and beat counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_burst_cnt <= '0;
      r_beat_cnt  <= '0;
    end else if (end_conv) begin
      r_burst_cnt <= '0;
      r_beat_cnt  <= '0;
    end else begin
      if (r_state == S_IDLE && op_start) begin
        r_burst_cnt <= '0;
        r_beat_cnt  <= '0;
      end
      if (r_state == S_STREAM && w_pop)
        r_beat_cnt <= w_last_beat ? '0 : r_beat_cnt + BEAT_W'(1);
      if (r_state == S_WAIT_DONE && wmst_done)
        r_burst_cnt <= r_burst_cnt + 32'd1;
    end
  end

  // FSM state register plus registered state-decoded outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_wmst_req   <= 1'b0;
      r_tvalid     <= 1'b0;
      r_drain_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_wmst_req   <= (w_state_nxt == S_REQ);
      r_tvalid     <= (w_state_nxt == S_STREAM);
      r_drain_done <= (w_state_nxt == S_DONE);
    end
  end

  // FSM next-state logic; end_conv overrides everything
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (op_start) w_state_nxt = S_WAIT_DATA;
      S_WAIT_DATA: if (r_cnt >= CNT_W'(BURST_LENGTH)) w_state_nxt = S_REQ;
      S_REQ:       w_state_nxt = S_STREAM;
      S_STREAM:    if (w_pop && w_last_beat) w_state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: if (wmst_done) w_state_nxt = w_last_burst ? S_DONE : S_WAIT_DATA;
      S_DONE:      w_state_nxt = S_DONE;
      default:     w_state_nxt = S_IDLE;
    endcase
    if (end_conv) w_state_nxt = S_IDLE;
  end

endmodule
